stream_turbo_encode: RTL and testbench



---
 rtl/stream_turbo_encode.sv | 212 +++++++++++++++++++++
 tb/tb_stream_turbo_encode.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stream_turbo_encode.sv
// ---------------------------------------------------------------------------
// stream_turbo_encode
//
// Streaming rate-1/3 turbo encoder. One information bit is accepted per cycle
// until a frame of N bits is buffered. The encoder then emits N data symbols
// followed by TAIL_BITS termination symbols. Each symbol is a triple:
//   y0 = systematic bit, y1 = parity of RSC1 (natural order),
//   y2 = parity of RSC2 (prime-interleaved order, pi(k) = k*P mod N).
// Both constituent codes are 4-state RSC, feedback 7, feedforward 5.
//
// Optional feature macro: STREAM_TURBO_ENCODE_BPSK_EN
//   When defined, each output bit is mapped to IEEE-754 single precision
//   (0 -> +1.0, 1 -> -1.0) and OW = BITS. Otherwise OW = 1 (raw code bits).
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   information bit offered
//   in_ready   encoder can accept a bit (high only while filling)
//   x          information bit
//   out_valid  y0/y1/y2 hold a valid symbol triple
//   out_last   final tail symbol of a frame
//   y0,y1,y2   systematic / RSC1 parity / RSC2 parity, OW bits each
// ---------------------------------------------------------------------------
module stream_turbo_encode #(
    parameter int N         = 8,
    parameter int P         = 3,
    parameter int TAIL_BITS = 2,
    parameter int BITS      = 32,
`ifdef STREAM_TURBO_ENCODE_BPSK_EN
    localparam int OW       = BITS
`else
    localparam int OW       = 1
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          x,
    output logic          out_valid,
    output logic          out_last,
    output logic [OW-1:0] y0,
    output logic [OW-1:0] y1,
    output logic [OW-1:0] y2
);

    localparam int         CW    = $clog2(N);
    localparam logic [CW:0] PSTEP = (CW+1)'(P % N);
    localparam logic [CW:0] NMOD  = (CW+1)'(N);

    if (TAIL_BITS != 2 || N < 2 || (P % N) == 0 || BITS < 1) begin : g_bad_params
        $error("stream_turbo_encode: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        TAIL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   pi_q, pi_d;
    logic [1:0]      rsc1_q, rsc1_d;
    logic [1:0]      rsc2_q, rsc2_d;
    logic [N-1:0]    frame_buf;

    logic            accept;
    logic            produce;
    logic            sym_last;
    logic            u1, u2;
    logic [2:0]      step1, step2;

    // One RSC trellis step. Returns {parity, next_state}.
    function automatic logic [2:0] rsc_step(input logic [1:0] s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a ^ s[0], a, s[1]};
    endfunction

    // Incremental interleaver address: (cur + P) mod N without a multiplier.
    function automatic logic [CW-1:0] pi_step(input logic [CW-1:0] cur);
        logic [CW:0] sum;
        sum = {1'b0, cur} + PSTEP;
        if (sum >= NMOD) begin
            sum = sum - NMOD;
        end
        return sum[CW-1:0];
    endfunction

    function automatic logic [OW-1:0] map_sym(input logic b);
`ifdef STREAM_TURBO_ENCODE_BPSK_EN
        return b ? OW'(32'hBF80_0000) : OW'(32'h3F80_0000);
`else
        return b;
`endif
    endfunction

    // The last tail symbol is still on the outputs during the first FILL
    // cycle, so in_ready waits for out_valid to fall.
    assign in_ready = (state_q == FILL) && !out_valid;
    assign accept   = in_valid && in_ready;

    // Symbols are computed one cycle ahead of display: the N-th accept edge
    // already registers symbol 0, so cnt holds the index of the next symbol
    // to produce while in EMIT/TAIL.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pi_d     = pi_q;
        produce  = 1'b0;
        sym_last = 1'b0;
        u1       = 1'b0;
        u2       = 1'b0;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (cnt_q == CW'(N-1)) begin
                        // bit 0 was written earlier and pi(0) = 0
                        produce = 1'b1;
                        u1      = frame_buf[0];
                        u2      = frame_buf[0];
                        state_d = EMIT;
                        cnt_d   = CW'(1);
                        pi_d    = pi_step('0);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                produce = 1'b1;
                u1      = frame_buf[cnt_q];
                u2      = frame_buf[pi_q];
                if (cnt_q == CW'(N-1)) begin
                    state_d = TAIL;
                    cnt_d   = '0;
                    pi_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    pi_d  = pi_step(pi_q);
                end
            end
            TAIL: begin
                // Termination input forces the feedback node to zero.
                produce = 1'b1;
                u1      = rsc1_q[1] ^ rsc1_q[0];
                u2      = rsc2_q[1] ^ rsc2_q[0];
                if (cnt_q == CW'(TAIL_BITS-1)) begin
                    sym_last = 1'b1;
                    state_d  = FILL;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
                pi_d    = '0;
            end
        endcase

        step1  = rsc_step(rsc1_q, u1);
        step2  = rsc_step(rsc2_q, u2);
        rsc1_d = produce ? step1[1:0] : rsc1_q;
        rsc2_d = produce ? step2[1:0] : rsc2_q;
        if (sym_last) begin
            rsc1_d = '0;
            rsc2_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            pi_q      <= '0;
            rsc1_q    <= '0;
            rsc2_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            y0        <= '0;
            y1        <= '0;
            y2        <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pi_q      <= pi_d;
            rsc1_q    <= rsc1_d;
            rsc2_q    <= rsc2_d;
            out_valid <= produce;
            out_last  <= sym_last;
            if (produce) begin
                y0 <= map_sym(u1);
                y1 <= map_sym(step1[2]);
                y2 <= map_sym(step2[2]);
            end
        end
    end

    // Frame storage carries data only; after reset cnt restarts at 0, so
    // stale contents are simply overwritten by the next frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_buf[cnt_q] <= x;
        end
    end

endmodule

// File: tb/tb_stream_turbo_encode.sv
// ---------------------------------------------------------------------------
// tb_stream_turbo_encode
//
// Scoreboard bench for stream_turbo_encode (N=8, P=3). Stimulus pushes the
// hand-computed symbol triples of each frame into a queue; a monitor on the
// falling edge pops and compares whenever out_valid is high, and also checks
// reset state, in_ready/out_valid exclusivity and first-symbol latency.
// ---------------------------------------------------------------------------
module tb_stream_turbo_encode;

    localparam int N = 8;
`ifdef STREAM_TURBO_ENCODE_BPSK_EN
    localparam int OW = 32;
`else
    localparam int OW = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          x;
    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic [OW-1:0] y0, y1, y2;

    stream_turbo_encode #(
        .N(N), .P(3), .TAIL_BITS(2), .BITS(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .out_valid(out_valid), .out_last(out_last),
        .y0(y0), .y1(y1), .y2(y2)
    );

    always #5 clk = ~clk;

    // {y0, y1, y2, last}
    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         sym_idx  = 0;
    int         acc_cnt  = 0;
    logic       first_due  = 1'b0;
    logic       final_chk  = 1'b0;
    logic       final_done = 1'b0;

    function automatic logic [OW-1:0] to_sym(input logic b);
`ifdef STREAM_TURBO_ENCODE_BPSK_EN
        return b ? 32'hBF80_0000 : 32'h3F80_0000;
`else
        return b;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic push_frame(input logic [0:9] e0, input logic [0:9] e1, input logic [0:9] e2);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({e0[i], e1[i], e2[i], (i == 9)});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last accept.
    task automatic send_frame(input logic [0:N-1] f, input bit gapped);
        int guard;
        for (int i = 0; i < N; i++) begin
            if (gapped) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            in_valid = 1'b1;
            x        = f[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        x        = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready",  32'(in_ready),  32'd1);
            check("rst_out_last",  32'(out_last),  32'd0);
            check("rst_y0",        32'(y0),        32'd0);
            exp_q.delete();
            acc_cnt   = 0;
            first_due = 1'b0;
        end else begin
            if (first_due) begin
                check("first_symbol_latency", 32'(out_valid), 32'd1);
                first_due = 1'b0;
            end
            check("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_symbol", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("y0[%0d]", sym_idx), 32'(y0), 32'(to_sym(e[3])));
                    check($sformatf("y1[%0d]", sym_idx), 32'(y1), 32'(to_sym(e[2])));
                    check($sformatf("y2[%0d]", sym_idx), 32'(y2), 32'(to_sym(e[1])));
                    check($sformatf("out_last[%0d]", sym_idx), 32'(out_last), 32'(e[0]));
                end
                sym_idx++;
            end else begin
                check("out_last_idle", 32'(out_last), 32'd0);
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (acc_cnt == N) begin
                    acc_cnt   = 0;
                    first_due = 1'b1;
                end
            end
            if (final_chk && !final_done) begin
                check("queue_drained", 32'(exp_q.size()), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // all-zero frame
        push_frame(10'b0000000000, 10'b0000000000, 10'b0000000000);
        send_frame(8'b00000000, 1'b0);

        // single 1 at bit 0; in_valid then held high with x=1 through EMIT/TAIL
        push_frame(10'b1000000001, 10'b1110110111, 10'b1110110111);
        send_frame(8'b10000000, 1'b0);
        in_valid = 1'b1;
        x        = 1'b1;

        // single 1 at bit 1 (interleaved to k=3); junk bits must not be consumed
        push_frame(10'b0100000011, 10'b0111011001, 10'b0001110111);
        send_frame(8'b01000000, 1'b0);

        // mixed frame, gapped input
        push_frame(10'b1101001010, 10'b1000010110, 10'b1011110111);
        send_frame(8'b11010010, 1'b1);

        // same frame, reset while symbol 4 is on the outputs
        push_frame(10'b1101001010, 10'b1000010110, 10'b1011110111);
        send_frame(8'b11010010, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // clean frames after the abandoned one
        push_frame(10'b0000000000, 10'b0000000000, 10'b0000000000);
        send_frame(8'b00000000, 1'b0);
        push_frame(10'b1000000001, 10'b1110110111, 10'b1110110111);
        send_frame(8'b10000000, 1'b0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        final_chk = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
